// File: rtl/rom_arbiter.sv
// Two-requester arbiter for the shared character ROM port (display high priority, aux low).
// Define ARB_RR_EN to replace fixed priority plus starvation guard with round-robin on conflicts.
module rom_arbiter #(
  parameter int ROM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       dispReq,
  input  logic [2:0] dispUser,
  input  logic [3:0] dispCol,
  output logic       dispGnt,
  output logic       dispValid,
  output logic [7:0] dispByte,
  input  logic       auxReq,
  input  logic [2:0] auxUser,
  input  logic [3:0] auxCol,
  output logic       auxGnt,
  output logic       auxValid,
  output logic [7:0] auxByte,
  output logic       romEn,
  output logic [2:0] romUser,
  output logic [3:0] romCol,
  input  logic [7:0] romByte,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RETURN} stateT;

  localparam logic [1:0] LAT_LAST = 2'(ROM_LAT);

  stateT      state, nextState;
  logic [1:0] latCnt;
  logic       owner;
  logic       sampling;
  logic       anyReq;
  logic       lastAccess;
  logic       pickAux;

  // RETURN doubles as a sampling slot so a waiting request wins the very next grant
  assign sampling   = (state == IDLE) || (state == RETURN);
  assign anyReq     = dispReq || auxReq;
  assign lastAccess = (state == ACCESS) && (latCnt == LAT_LAST);

`ifdef ARB_RR_EN
  logic lastWinner;

  always_comb begin
    pickAux = auxReq && (!dispReq || !lastWinner);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      lastWinner <= 1'b1;
    end else if (sampling && anyReq) begin
      lastWinner <= pickAux;
    end
  end
`else
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0] starveCnt;

  always_comb begin
    pickAux = auxReq && (!dispReq || (starveCnt == STARVE_LIM));
  end

  // Counts display grants won over a waiting aux; any sample without aux pending clears it
  always_ff @(posedge clock) begin
    if (reset) begin
      starveCnt <= 4'd0;
    end else if (sampling) begin
      if (!auxReq || pickAux) begin
        starveCnt <= 4'd0;
      end else if (starveCnt != 4'hF) begin
        starveCnt <= starveCnt + 4'd1;
      end
    end
  end
`endif

  always_comb begin
    nextState = state;
    dispGnt   = 1'b0;
    auxGnt    = 1'b0;
    dispValid = 1'b0;
    auxValid  = 1'b0;
    romEn     = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (anyReq) nextState = ACCESS;
      end
      ACCESS: begin
        romEn   = 1'b1;
        dispGnt = (latCnt == 2'd0) && !owner;
        auxGnt  = (latCnt == 2'd0) && owner;
        if (latCnt == LAT_LAST) nextState = RETURN;
      end
      RETURN: begin
        dispValid = !owner;
        auxValid  = owner;
        nextState = anyReq ? ACCESS : IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // Winner's address is latched at the sampling edge and held for the whole access
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      latCnt   <= 2'd0;
      owner    <= 1'b0;
      romUser  <= 3'd0;
      romCol   <= 4'd0;
      dispByte <= 8'd0;
      auxByte  <= 8'd0;
    end else begin
      state <= nextState;
      if (sampling && anyReq) begin
        owner   <= pickAux;
        romUser <= pickAux ? auxUser : dispUser;
        romCol  <= pickAux ? auxCol : dispCol;
        latCnt  <= 2'd0;
      end else if ((state == ACCESS) && !lastAccess) begin
        latCnt <= latCnt + 2'd1;
      end
      if (lastAccess) begin
        if (owner) begin
          auxByte <= romByte;
        end else begin
          dispByte <= romByte;
        end
      end
    end
  end

endmodule

// File: tb/tb_rom_arbiter.sv
// Drives three arbiters (ROM_LAT 0, 1, 3) from shared directed stimulus and checks each
// against a transaction-level model every cycle, plus literal expectations.
module tb_rom_arbiter;

  localparam int NI     = 3;
  localparam int STARVE = 4;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset;
  logic       dispReq, auxReq;
  logic [2:0] dispUser, auxUser;
  logic [3:0] dispCol, auxCol;

  logic [NI-1:0]      dGnt, dValid, aGnt, aValid, romEn, busy;
  logic [NI-1:0][7:0] dByte, aByte, romByte;
  logic [NI-1:0][2:0] romUser;
  logic [NI-1:0][3:0] romCol;

  int checks = 0;
  int errors = 0;

  function automatic logic [7:0] romFn(input logic [2:0] u, input logic [3:0] c);
    return {u, c, 1'b0} ^ 8'hCF;
  endfunction

  function automatic int latOf(input int i);
    return (i == 0) ? 0 : ((i == 1) ? 1 : 3);
  endfunction

  for (genvar g = 0; g < NI; g++) begin : gInst
    localparam int LAT = (g == 0) ? 0 : ((g == 1) ? 1 : 3);
    logic [7:0] s0, s1, s2, s3;

    rom_arbiter #(.ROM_LAT(LAT), .STARVE_MAX(STARVE)) dut (
      .clock(clock), .reset(reset),
      .dispReq(dispReq), .dispUser(dispUser), .dispCol(dispCol),
      .dispGnt(dGnt[g]), .dispValid(dValid[g]), .dispByte(dByte[g]),
      .auxReq(auxReq), .auxUser(auxUser), .auxCol(auxCol),
      .auxGnt(aGnt[g]), .auxValid(aValid[g]), .auxByte(aByte[g]),
      .romEn(romEn[g]), .romUser(romUser[g]), .romCol(romCol[g]),
      .romByte(romByte[g]), .busy(busy[g])
    );

    // ROM with LAT-cycle read pipeline; data is only meaningful once romEn has been high LAT cycles
    assign s0 = romEn[g] ? romFn(romUser[g], romCol[g]) : 8'h00;
    always @(posedge clock) begin
      s1 <= s0;
      s2 <= s1;
      s3 <= s2;
    end
    assign romByte[g] = (LAT == 0) ? s0 : ((LAT == 1) ? s1 : ((LAT == 2) ? s2 : s3));
  end

  task automatic checkOutput(input string name, input int inst, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s inst%0d: got %0h, expected %0h", name, inst, act, exp);
    end
  endtask

  // Model: age = cycles since grant (-1 idle); access spans ages 0..LAT, return is age LAT+1
  int         age[NI];
  logic       mOwner[NI];
  logic [2:0] mUser[NI];
  logic [3:0] mCol[NI];
  logic [7:0] mDByte[NI], mAByte[NI];
  int         starve[NI];
  logic       lastWin[NI];
  bit         modelReady;

  byte gq[$];
  int  cyc;
  int  lastG[NI], spacing[NI], runLen[NI], lastRun[NI];

  initial begin
    int  lat;
    bit  inAcc;
    int  w;
    modelReady = 0;
    cyc = 0;
    for (int i = 0; i < NI; i++) begin
      lastG[i] = -1; spacing[i] = 0; runLen[i] = 0; lastRun[i] = 0; age[i] = -1;
    end
    forever begin
      @(negedge clock);
      cyc++;
      if (modelReady) begin
        if (dGnt[1]) gq.push_back(8'h44);
        else if (aGnt[1]) gq.push_back(8'h41);
        for (int i = 0; i < NI; i++) begin
          if (dGnt[i]) begin
            if (lastG[i] >= 0) spacing[i] = cyc - lastG[i];
            lastG[i] = cyc;
          end
          if (romEn[i]) runLen[i]++;
          else if (runLen[i] > 0) begin
            lastRun[i] = runLen[i];
            runLen[i] = 0;
          end
          lat = latOf(i);
          inAcc = (age[i] >= 0) && (age[i] <= lat);
          checkOutput("dispGnt", i, dGnt[i], (age[i] == 0) && !mOwner[i]);
          checkOutput("auxGnt", i, aGnt[i], (age[i] == 0) && mOwner[i]);
          checkOutput("romEn", i, romEn[i], inAcc);
          checkOutput("busy", i, busy[i], age[i] >= 0);
          checkOutput("dispValid", i, dValid[i], (age[i] == lat + 1) && !mOwner[i]);
          checkOutput("auxValid", i, aValid[i], (age[i] == lat + 1) && mOwner[i]);
          checkOutput("dispByte", i, dByte[i], mDByte[i]);
          checkOutput("auxByte", i, aByte[i], mAByte[i]);
          if (inAcc) begin
            checkOutput("romUser", i, romUser[i], mUser[i]);
            checkOutput("romCol", i, romCol[i], mCol[i]);
          end
        end
      end
      // Advance model with the inputs the coming rising edge will sample
      for (int i = 0; i < NI; i++) begin
        lat = latOf(i);
        if (reset) begin
          age[i] = -1; mOwner[i] = 0; mUser[i] = 0; mCol[i] = 0;
          mDByte[i] = 0; mAByte[i] = 0; starve[i] = 0; lastWin[i] = 1;
        end else if (age[i] < 0 || age[i] == lat + 1) begin
          if (dispReq && auxReq) begin
`ifdef ARB_RR_EN
            w = lastWin[i] ? 0 : 1;
`else
            w = (starve[i] == STARVE) ? 1 : 0;
`endif
          end else if (dispReq) w = 0;
          else if (auxReq) w = 1;
          else w = -1;
          if (!auxReq || w == 1) starve[i] = 0;
          else if (w == 0 && starve[i] < 15) starve[i]++;
          if (w < 0) age[i] = -1;
          else begin
            age[i] = 0;
            mOwner[i] = (w == 1);
            mUser[i] = (w == 1) ? auxUser : dispUser;
            mCol[i] = (w == 1) ? auxCol : dispCol;
            lastWin[i] = (w == 1);
          end
        end else begin
          age[i]++;
          if (age[i] == lat + 1) begin
            if (mOwner[i]) mAByte[i] = romFn(mUser[i], mCol[i]);
            else mDByte[i] = romFn(mUser[i], mCol[i]);
          end
        end
      end
      if (reset) modelReady = 1;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic d, input logic [2:0] du, input logic [3:0] dc,
                               input logic a, input logic [2:0] au, input logic [3:0] ac);
    dispReq = d; dispUser = du; dispCol = dc;
    auxReq = a; auxUser = au; auxCol = ac;
  endtask

  task automatic checkOrder(input string name, input int base, input int n, input string exp);
    string got;
    bit    bad;
    got = "";
    bad = 0;
    for (int k = 0; k < n; k++) begin
      if (gq.size() > base + k) begin
        got = $sformatf("%s%c", got, gq[base + k]);
        if (gq[base + k] != exp[k]) bad = 1;
      end else bad = 1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("[TB] FAIL %s: got %s, expected %s", name, got, exp);
    end
  endtask

  initial begin
    int base;
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0);
    tick();
    tick();
    checkOutput("rstRomEn", 1, romEn[1], 0);
    checkOutput("rstBusy", 1, busy[1], 0);
    checkOutput("rstRomUser", 1, romUser[1], 0);
    checkOutput("rstDispByte", 1, dByte[1], 0);
    reset = 1'b0;
    tick();

    // Single display fetch through the LAT=1 arbiter
    applyStimulus(1, 3, 5, 0, 0, 0);
    tick();
    checkOutput("t1Gnt", 1, dGnt[1], 1);
    checkOutput("t1RomEn", 1, romEn[1], 1);
    checkOutput("t1RomUser", 1, romUser[1], 3);
    checkOutput("t1RomCol", 1, romCol[1], 5);
    applyStimulus(0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("t1RomEn2", 1, romEn[1], 1);
    checkOutput("t1RomCol2", 1, romCol[1], 5);
    tick();
    checkOutput("t1Valid", 1, dValid[1], 1);
    checkOutput("t1Byte", 1, dByte[1], 8'hA5);
    checkOutput("t1AuxValid", 1, aValid[1], 0);
    repeat (6) tick();

    // Both requesters held continuously
    base = gq.size();
    applyStimulus(1, 1, 2, 1, 4, 6);
    for (int k = 0; k < 60 && gq.size() < base + 10; k++) tick();
`ifdef ARB_RR_EN
    checkOrder("bothOrder", base, 10, "ADADADADAD");
`else
    checkOrder("bothOrder", base, 10, "DDDDADDDDA");
`endif
    applyStimulus(0, 0, 0, 0, 0, 0);
    repeat (8) tick();

    base = gq.size();
    applyStimulus(0, 0, 0, 1, 2, 3);
    for (int k = 0; k < 30 && gq.size() < base + 3; k++) tick();
    checkOrder("auxOnlyOrder", base, 3, "AAA");
    applyStimulus(0, 0, 0, 0, 0, 0);
    repeat (8) tick();

    // Back-to-back display requests with a column that changes every cycle
    applyStimulus(1, 2, 0, 0, 0, 0);
    for (int k = 0; k < 16; k++) begin
      dispCol = dispCol + 4'd1;
      tick();
    end
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("spacingLat0", 0, spacing[0], 2);
    checkOutput("spacingLat3", 2, spacing[2], 5);
    checkOutput("romEnRunLat0", 0, lastRun[0], 1);
    checkOutput("romEnRunLat3", 2, lastRun[2], 4);
    repeat (8) tick();

    // Reset during the second access cycle of the LAT=3 arbiter
    applyStimulus(1, 1, 1, 0, 0, 0);
    tick();
    checkOutput("rmRomEn", 2, romEn[2], 1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("rmRomEnOff", 2, romEn[2], 0);
    checkOutput("rmBusyOff", 2, busy[2], 0);
    checkOutput("rmDispByte", 2, dByte[2], 0);
    checkOutput("rmNoValid", 2, dValid[2], 0);
    tick();
    applyStimulus(1, 5, 9, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 10 && !dValid[2]; k++) tick();
    checkOutput("rmFreshValid", 2, dValid[2], 1);
    checkOutput("rmFreshByte", 2, dByte[2], 8'h7D);
    repeat (8) tick();

    // Aux access with a display request arriving mid-access (LAT=1)
    applyStimulus(0, 0, 0, 1, 2, 7);
    tick();
    checkOutput("adAuxGnt", 1, aGnt[1], 1);
    applyStimulus(1, 6, 1, 0, 0, 0);
    tick();
    checkOutput("adNoDispGnt", 1, dGnt[1], 0);
    checkOutput("adDispHold1", 1, dByte[1], 8'h7D);
    tick();
    checkOutput("adAuxValid", 1, aValid[1], 1);
    checkOutput("adAuxByte", 1, aByte[1], 8'h81);
    checkOutput("adDispHold2", 1, dByte[1], 8'h7D);
    tick();
    checkOutput("adDispGnt", 1, dGnt[1], 1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("adDispHold3", 1, dByte[1], 8'h7D);
    tick();
    checkOutput("adDispValid", 1, dValid[1], 1);
    checkOutput("adDispByte", 1, dByte[1], 8'h0D);
    repeat (6) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rom_arbiter.md
Name: rom_arbiter

Overview:
- Shares the single character ROM port (readEn / user / column address, romByte return) between two requesters.
- Display requester: the display controller's glyph-row fetch, high priority.
- Aux requester: a secondary fetcher, e.g. a preview or banner engine, low priority.
- Serialises accesses, holds the address stable for the ROM read latency, and returns the byte to the owner with a one-cycle valid pulse.
- Sits between the display controller / aux engine and the ROM controller, clocked by the pixel clock.

Parameters:
- ROM_LAT, 1: ROM read latency in cycles from romEn assertion to romByte valid. Legal range 0..3; 0 means combinational ROM.
- STARVE_MAX, 4: consecutive display grants allowed while aux is pending before aux is forced. Legal range 1..15.

Ports:
- clock  in  1  pixel clock; single clock domain
- reset  in  1  synchronous, active-high reset
- dispReq  in  1  display request; held until dispGnt
- dispUser  in  3  display ROM user/character select
- dispCol  in  4  display ROM column/row index
- dispGnt  out  1  one-cycle grant pulse to display
- dispValid  out  1  one-cycle pulse; dispByte valid
- dispByte  out  8  returned ROM byte for display
- auxReq  in  1  aux request; held until auxGnt
- auxUser  in  3  aux ROM user select
- auxCol  in  4  aux ROM column index
- auxGnt  out  1  one-cycle grant pulse to aux
- auxValid  out  1  one-cycle pulse; auxByte valid
- auxByte  out  8  returned ROM byte for aux
- romEn  out  1  ROM read enable
- romUser  out  3  ROM user select
- romCol  out  4  ROM column select
- romByte  in  8  ROM data
- busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset: all outputs are 0, FSM is in IDLE, starvation counter is 0, owner flag is cleared.
- FSM has three states: IDLE, ACCESS, RETURN.
- IDLE: samples dispReq and auxReq on each clock edge. Requests are ignored in every other state.
- If any request is sampled in IDLE, the next cycle is ACCESS.
- Grant cycle (first ACCESS cycle): winner's Gnt = 1 for exactly one cycle.
  - romEn = 1.
  - romUser/romCol are loaded from the winner's User/Col, registered at the IDLE edge.
- ACCESS lasts ROM_LAT+1 cycles.
  - romEn stays high and the address stays stable throughout.
  - A latency counter counts 0..ROM_LAT.
  - romByte is captured at the end of the last ACCESS cycle.
- RETURN (1 cycle): owner's Valid = 1 and owner's Byte = captured value; romEn = 0.
  - FSM is treated as IDLE for sampling during this cycle, so a request present in RETURN wins the next grant.
- Latency: request sampled at end of cycle 0 → Gnt in cycle 1 → Valid in cycle 2+ROM_LAT. The next grant is possible in cycle 3+ROM_LAT, giving throughput of one access per ROM_LAT+2 cycles.
- Byte outputs hold their last value between Valid pulses. The non-owner's Byte does not change.
- Requester rule: deassert Req in the cycle after Gnt unless another access is wanted. A Req still high when next sampled is a new request.
- Arbitration when only one requester is active: that requester wins.
- Arbitration when both are active: display wins, unless the starvation counter equals STARVE_MAX, in which case aux wins.
- Starvation counter:
  - Increments (saturating at 15) on each display grant issued while auxReq = 1.
  - Clears to 0 on an aux grant, or in any IDLE/RETURN sample where auxReq = 0.
- Reset mid-access: the in-flight read is discarded, no Valid is issued, and romEn drops in the cycle after reset is sampled.
- The User/Col inputs of a non-winning requester are ignored.

Optional Feature:
- Macro: ARB_RR_EN.
- Defined: conflicts are resolved round-robin.
  - A 1-bit lastWinner register (reset = aux, so display wins the first conflict) updates on every grant.
  - On conflict, the requester that was not lastWinner wins.
  - The starvation counter and STARVE_MAX are unused.
- Undefined: fixed display priority with the starvation guard, as described in Behaviour.
- All other timing is identical in both builds.

Test Plan:
- ROM_LAT=1, dispReq pulse with dispUser=3, dispCol=5, ROM model returns 0xA5 → dispGnt in cycle 1; romEn high in cycles 1-2 with romUser=3, romCol=5; dispValid in cycle 3 with dispByte=0xA5; auxValid stays 0.
- Both Req held high continuously, STARVE_MAX=4, ARB_RR_EN undefined → grant order D,D,D,D,A,D,D,D,D,A; each Valid follows its Gnt by ROM_LAT+1 cycles.
- ARB_RR_EN defined, both Req high → grants alternate D,A,D,A; auxReq alone → A,A,A.
- ROM_LAT=0 and ROM_LAT=3 with back-to-back dispReq → grant spacing of 2 and 5 cycles respectively; romCol stable for 1 and 4 cycles respectively.
- Reset asserted in the 2nd ACCESS cycle (ROM_LAT=3) → no dispValid; romEn, busy and dispByte are 0 the next cycle; a fresh request afterwards completes normally.
- auxReq alone, dispReq raised during aux ACCESS → aux completes with auxValid; display is granted in the cycle after RETURN; dispByte is unchanged until its own dispValid.
